// File: rtl/pe_pkg.sv
// Shared defaults, derived beat count and drain FSM state type for the PE column drain path.
package pe_pkg;
  localparam int PE_COLS      = 16;
  localparam int PE_IN_WIDTH  = 48;
  localparam int PE_OUT_WIDTH = 32;
  localparam int PE_LANES     = 4;
  localparam int PE_DEPTH     = 4;
  localparam int BEATS        = PE_COLS / PE_LANES;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_e;

  function automatic int beats_of(input int cols, input int lanes);
    return cols / lanes;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pe_drain_row_fifo.sv
// Register FIFO of whole array rows; a push into a full FIFO is accepted when the head pops the same cycle.
module pe_drain_row_fifo import pe_pkg::*; #(
  parameter int WIDTH = PE_COLS * PE_IN_WIDTH,
  parameter int DEPTH = PE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         next_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     accept_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign accept_o = push_i & (~full_o | pop_i);
  assign head_o   = mem[rd_ptr_q];
  assign next_o   = mem[rd_ptr_q + PTR_W'(1)];
  assign count_o  = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(accept_o);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + CNT_W'(accept_o) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Row storage carries data only; validity lives in the pointers and count.
  always_ff @(posedge clk) begin
    if (accept_o) mem[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/pe_sys_drain.sv
// Captures PE array rows into a row FIFO and serialises them as LANES-wide beats on a valid/ready stream.
// Define PE_DRAIN_SAT_EN to signed-saturate each word to OUT_WIDTH instead of truncating.
module pe_sys_drain import pe_pkg::*; #(
  parameter int COLS      = PE_COLS,
  parameter int IN_WIDTH  = PE_IN_WIDTH,
  parameter int OUT_WIDTH = PE_OUT_WIDTH,
  parameter int LANES     = PE_LANES,
  parameter int DEPTH     = PE_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COLS*IN_WIDTH-1:0]     bottom_in,
  input  logic                         capture_in,
  output logic [LANES*OUT_WIDTH-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         ovf_out,
  input  logic                         ovf_clr_in,
  output logic [$clog2(DEPTH):0]       rows_pending
);
  localparam int NB     = beats_of(COLS, LANES);
  localparam int BEAT_W = clog2_min1(NB);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int ROW_W  = COLS * IN_WIDTH;
  localparam int IDX_W  = $clog2(ROW_W);

  function automatic logic [OUT_WIDTH-1:0] narrow(input logic signed [IN_WIDTH-1:0] v);
`ifdef PE_DRAIN_SAT_EN
    logic signed [IN_WIDTH-1:0] maxv;
    logic signed [IN_WIDTH-1:0] minv;
    maxv = {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    minv = {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    if (v > maxv)      narrow = maxv[OUT_WIDTH-1:0];
    else if (v < minv) narrow = minv[OUT_WIDTH-1:0];
    else               narrow = v[OUT_WIDTH-1:0];
`else
    narrow = OUT_WIDTH'(v);
`endif
  endfunction

  logic [ROW_W-1:0]           head_row, next_row, nxt_head_row;
  logic [CNT_W-1:0]           fifo_cnt, cnt_after;
  logic                       fifo_full, fifo_empty, accept, fire, pop;
  drain_state_e               state_q, state_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic [LANES*OUT_WIDTH-1:0] data_q, data_d;
  logic                       last_q, last_d, ovf_q, ovf_d;

  pe_drain_row_fifo #(.WIDTH(ROW_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (capture_in),
    .pop_i    (pop),
    .wdata_i  (bottom_in),
    .head_o   (head_row),
    .next_o   (next_row),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .accept_o (accept),
    .count_o  (fifo_cnt)
  );

  assign fire      = (state_q == SEND) & out_ready;
  assign pop       = fire & (beat_q == BEAT_W'(NB-1)) & ~fifo_empty;
  assign cnt_after = fifo_cnt + CNT_W'(accept) - CNT_W'(pop);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: if (cnt_after != '0) state_d = SEND;
      SEND: begin
        if (fire) begin
          if (beat_q == BEAT_W'(NB-1)) begin
            beat_d = '0;
            if (cnt_after == '0) state_d = IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The output register is loaded from the head row as it will be after this cycle's push/pop,
  // bypassing bottom_in when the incoming row becomes the head.
  always_comb begin
    logic signed [IN_WIDTH-1:0] word;
    word = '0;
    if (cnt_after != '0 && (fifo_cnt - CNT_W'(pop)) == '0) nxt_head_row = bottom_in;
    else if (pop)                                          nxt_head_row = next_row;
    else                                                   nxt_head_row = head_row;
    data_d = '0;
    last_d = 1'b0;
    if (state_d == SEND) begin
      for (int l = 0; l < LANES; l++) begin
        word = nxt_head_row[IDX_W'((int'(beat_d) * LANES + l) * IN_WIDTH) +: IN_WIDTH];
        data_d[l*OUT_WIDTH +: OUT_WIDTH] = narrow(word);
      end
      last_d = (beat_d == BEAT_W'(NB-1));
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (capture_in & fifo_full & ~pop) ovf_d = 1'b1;
    else if (ovf_clr_in)               ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid    = (state_q == SEND);
  assign out_data     = data_q;
  assign out_last     = last_q;
  assign ovf_out      = ovf_q;
  assign rows_pending = fifo_cnt;
endmodule

// File: tb/tb_pe_sys_drain.sv
// Scoreboard bench for pe_sys_drain: stimulus queues expected beats, a negedge monitor compares them.
module tb_pe_sys_drain;
  localparam int COLS = 16, IN_W = 48, OUT_W = 32, LANES = 4, DEPTH = 4, NB = COLS / LANES;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [COLS*IN_W-1:0]    bottom_in;
  logic                    capture_in, out_ready, ovf_clr_in;
  logic [LANES*OUT_W-1:0]  out_data;
  logic                    out_valid, out_last, ovf_out;
  logic [$clog2(DEPTH):0]  rows_pending;

  typedef struct packed {
    logic [LANES*OUT_W-1:0] data;
    logic                   last;
  } beat_t;

  beat_t sb[$];
  int errors = 0;
  int checks = 0;

  pe_sys_drain dut (
    .clk          (clk),
    .rst          (rst),
    .bottom_in    (bottom_in),
    .capture_in   (capture_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .ovf_out      (ovf_out),
    .ovf_clr_in   (ovf_clr_in),
    .rows_pending (rows_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [COLS*IN_W-1:0] ramp_row(input int base);
    logic [COLS*IN_W-1:0] r;
    logic signed [IN_W-1:0] v;
    r = '0;
    for (int c = 0; c < COLS; c++) begin
      v = base + c + 1;
      r[c*IN_W +: IN_W] = v;
    end
    return r;
  endfunction

  task automatic push_ramp(input int base);
    beat_t b;
    logic [OUT_W-1:0] w;
    for (int k = 0; k < NB; k++) begin
      b = '0;
      for (int l = 0; l < LANES; l++) begin
        w = base + k * LANES + l + 1;
        b.data[l*OUT_W +: OUT_W] = w;
      end
      b.last = (k == NB - 1);
      sb.push_back(b);
    end
  endtask

  task automatic capture(input logic [COLS*IN_W-1:0] row);
    bottom_in  = row;
    capture_in = 1'b1;
    tick();
    capture_in = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    check({"drained_", name}, sb.size(), 0);
    tick();
    tick();
    check({"idle_", name}, out_valid, 1'b0);
  endtask

  // Monitor: compare each accepted beat and verify stalls hold data/last.
  initial begin
    logic  held_v;
    beat_t held;
    beat_t exp;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("stall_hold_data", out_data, held.data);
          check("stall_hold_last", out_last, held.last);
        end
        if (out_valid && out_ready) begin
          check("beat_expected", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            exp = sb.pop_front();
            check("beat_data", out_data, exp.data);
            check("beat_last", out_last, exp.last);
          end
          held_v = 1'b0;
        end else if (out_valid) begin
          held_v    = 1'b1;
          held.data = out_data;
          held.last = out_last;
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]            pat;
    logic [COLS*IN_W-1:0]  nrow;
    beat_t                 b;

    rst        = 1'b1;
    bottom_in  = '0;
    capture_in = 1'b0;
    out_ready  = 1'b0;
    ovf_clr_in = 1'b0;
    #12;
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_data", out_data, 0);
    check("rst_ovf", ovf_out, 1'b0);
    check("rst_pending", rows_pending, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single row, columns 1..16
    out_ready = 1'b1;
    b.data = 128'h00000004_00000003_00000002_00000001; b.last = 1'b0; sb.push_back(b);
    b.data = 128'h00000008_00000007_00000006_00000005; b.last = 1'b0; sb.push_back(b);
    b.data = 128'h0000000C_0000000B_0000000A_00000009; b.last = 1'b0; sb.push_back(b);
    b.data = 128'h00000010_0000000F_0000000E_0000000D; b.last = 1'b1; sb.push_back(b);
    capture(ramp_row(0));
    check("single_valid_t1", out_valid, 1'b1);
    check("single_pending", rows_pending, 1);
    wait_drain("single", 20);

    // Back-to-back rows, including negative values, with no bubble
    push_ramp(-20);
    push_ramp(50);
    capture(ramp_row(-20));
    capture(ramp_row(50));
    for (int i = 0; i < 7; i++) begin
      check("no_bubble", out_valid, 1'b1);
      tick();
    end
    wait_drain("b2b", 20);

    // Backpressure
    pat = 8'b1110_1001;
    push_ramp(100);
    capture(ramp_row(100));
    for (int i = 0; i < 8; i++) begin
      out_ready = pat[i];
      tick();
    end
    out_ready = 1'b1;
    wait_drain("bp", 20);

    // Overflow: five captures with the sink stalled
    out_ready = 1'b0;
    push_ramp(200);
    push_ramp(300);
    push_ramp(400);
    push_ramp(500);
    for (int r = 0; r < 5; r++) capture(ramp_row(200 + r * 100));
    check("ovf_set", ovf_out, 1'b1);
    check("ovf_pending", rows_pending, 4);
    ovf_clr_in = 1'b1;
    tick();
    ovf_clr_in = 1'b0;
    check("ovf_clr", ovf_out, 1'b0);
    out_ready = 1'b1;
    wait_drain("ovf", 40);

    // Full FIFO with head last beat retiring alongside a capture
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      push_ramp(700 + r * 100);
      capture(ramp_row(700 + r * 100));
    end
    check("fp_full_pending", rows_pending, 4);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("fp_last_shown", out_last, 1'b1);
    push_ramp(1100);
    capture(ramp_row(1100));
    out_ready = 1'b0;
    check("fp_pending", rows_pending, 4);
    check("fp_no_ovf", ovf_out, 1'b0);
    out_ready = 1'b1;
    wait_drain("fullpop", 60);

    // Narrowing
    nrow = '0;
    nrow[0*IN_W +: IN_W] = 48'h0001_0000_0005;
    nrow[1*IN_W +: IN_W] = 48'hFF00_0000_0000;
    nrow[2*IN_W +: IN_W] = 48'h0000_7FFF_FFFF;
    nrow[3*IN_W +: IN_W] = 48'hFFFF_8000_0000;
    nrow[4*IN_W +: IN_W] = 48'h0000_8000_0000;
`ifdef PE_DRAIN_SAT_EN
    b.data = 128'h80000000_7FFFFFFF_80000000_7FFFFFFF; b.last = 1'b0; sb.push_back(b);
    b.data = 128'h00000000_00000000_00000000_7FFFFFFF; b.last = 1'b0; sb.push_back(b);
`else
    b.data = 128'h80000000_7FFFFFFF_00000000_00000005; b.last = 1'b0; sb.push_back(b);
    b.data = 128'h00000000_00000000_00000000_80000000; b.last = 1'b0; sb.push_back(b);
`endif
    b.data = '0; b.last = 1'b0; sb.push_back(b);
    b.data = '0; b.last = 1'b1; sb.push_back(b);
    capture(nrow);
    wait_drain("narrow", 20);

    // Reset mid-drain at beat 2
    push_ramp(2000);
    capture(ramp_row(2000));
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_last", out_last, 1'b0);
    check("mid_rst_pending", rows_pending, 0);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", out_valid, 1'b0);
    push_ramp(3000);
    capture(ramp_row(3000));
    wait_drain("post_rst", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
